imem_load_controller: RTL and testbench

IMEM_LOAD_CONTROLLER -- requirements
Module: imem_load_controller

---
 rtl/imem_load_controller_if.sv | 40 ++++
 rtl/imem_load_controller.sv | 136 +++++++++++++
 tb/tb_imem_load_controller.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_load_controller_if.sv
// imem_load_controller_if
//   Bundles the host load request, the host word stream, the instruction
//   memory write/read ports and the status outputs of the load controller.
//   master : host / memory side (drives start, abort, base_addr, word_count,
//            in_data, in_valid, mem_rd_data; observes everything else)
//   slave  : the controller itself
interface imem_load_controller_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_enable;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              core_stall;
    logic              busy;
    logic              done;
    logic              error;
    logic [DATA_W-1:0] checksum;

    modport master (
        output start, abort, base_addr, word_count, in_data, in_valid, mem_rd_data,
        input  in_ready, mem_wr_addr, mem_wr_data, mem_wr_enable, mem_rd_addr,
               core_stall, busy, done, error, checksum
    );

    modport slave (
        input  start, abort, base_addr, word_count, in_data, in_valid, mem_rd_data,
        output in_ready, mem_wr_addr, mem_wr_data, mem_wr_enable, mem_rd_addr,
               core_stall, busy, done, error, checksum
    );
endinterface

// File: rtl/imem_load_controller.sv
// imem_load_controller
//   Streams host words into an instruction memory write port, then reads the
//   loaded range back through a read port and compares the readback sum with
//   the sum of the accepted words.
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : imem_load_controller_if.slave (request, word stream, memory
//           ports, stall/busy/done/error/checksum status)
module imem_load_controller #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    imem_load_controller_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_VERIFY,
        S_DONE
    } state_t;

    // Memory depth expressed in word_count width.
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   wr_cnt;
    logic [ADDR_W:0]   rd_cnt;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              error_q;
    logic [DATA_W-1:0] checksum_q;
    logic [DATA_W-1:0] rd_sum;
    logic [DATA_W-1:0] rd_sum_nxt;

    assign rd_sum_nxt = rd_sum + bus.mem_rd_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            base_q     <= '0;
            count_q    <= '0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_en      <= 1'b0;
            rd_addr    <= '0;
            error_q    <= 1'b0;
            checksum_q <= '0;
            rd_sum     <= '0;
        end else begin
            // Write strobe is a single-cycle pulse per accepted beat.
            wr_en <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        error_q    <= 1'b0;
                        checksum_q <= '0;
                        wr_cnt     <= '0;
                        rd_cnt     <= '0;
                        base_q     <= bus.base_addr;
                        count_q    <= bus.word_count;
                        if (bus.word_count == '0) begin
                            state <= S_DONE;
                        end else if (bus.word_count > DEPTH) begin
                            state   <= S_DONE;
                            error_q <= 1'b1;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    // abort wins over a beat arriving in the same cycle.
                    if (bus.abort) begin
                        state <= S_IDLE;
                    end else if (bus.in_valid) begin
                        wr_en      <= 1'b1;
                        wr_addr    <= base_q + wr_cnt[ADDR_W-1:0];
                        wr_data    <= bus.in_data;
                        checksum_q <= checksum_q + bus.in_data;
                        wr_cnt     <= wr_cnt + 1'b1;
                        if (wr_cnt == count_q - 1'b1)
                            state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    // Final write is on the memory port this cycle; reading
                    // starts only once it has landed.
                    if (bus.abort) begin
                        state <= S_IDLE;
                    end else begin
                        rd_addr <= base_q;
                        rd_cnt  <= '0;
                        rd_sum  <= '0;
                        state   <= S_VERIFY;
                    end
                end
                S_VERIFY: begin
                    if (bus.abort) begin
                        state <= S_IDLE;
                    end else begin
                        rd_sum  <= rd_sum_nxt;
                        rd_addr <= rd_addr + 1'b1;
                        rd_cnt  <= rd_cnt + 1'b1;
                        if (rd_cnt == count_q - 1'b1) begin
                            state <= S_DONE;
                            if (rd_sum_nxt != checksum_q)
                                error_q <= 1'b1;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready      = (state == S_LOAD);
    assign bus.busy          = (state != S_IDLE);
    assign bus.core_stall    = (state != S_IDLE);
    assign bus.done          = (state == S_DONE);
    assign bus.mem_wr_enable = wr_en;
    assign bus.mem_wr_addr   = wr_addr;
    assign bus.mem_wr_data   = wr_data;
    assign bus.mem_rd_addr   = rd_addr;
    assign bus.error         = error_q;
    assign bus.checksum      = checksum_q;
endmodule

// File: tb/tb_imem_load_controller.sv
module tb_imem_load_controller;
    localparam int AW = 6;
    localparam int DW = 16;
    localparam int DEPTH = 1 << AW;

    logic clock;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    imem_load_controller_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

    imem_load_controller #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory model: synchronous write, combinational read,
    // optional single-bit corruption of one location on readback.
    logic [DW-1:0] mem [DEPTH];
    bit            corrupt = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;
    always @(posedge clock)
        if (ifc.mem_wr_enable) mem[ifc.mem_wr_addr] <= ifc.mem_wr_data;
    assign ifc.mem_rd_data = mem[ifc.mem_rd_addr] ^
        ((corrupt && ifc.mem_rd_addr == corrupt_addr) ? 16'h0001 : 16'h0000);

    // Event log: accepted beats, observed writes, done pulses (by cycle).
    int cyc = 0;
    int done_cnt = 0;
    int acc_cyc_q[$];
    int wr_cyc_q[$];
    int wr_addr_q[$];
    int wr_data_q[$];
    always @(posedge clock) begin
        cyc = cyc + 1;
        if (!reset) begin
            if (ifc.in_valid && ifc.in_ready && !ifc.abort) acc_cyc_q.push_back(cyc);
            if (ifc.mem_wr_enable) begin
                wr_cyc_q.push_back(cyc);
                wr_addr_q.push_back(int'(ifc.mem_wr_addr));
                wr_data_q.push_back(int'(ifc.mem_wr_data));
            end
            if (ifc.done) done_cnt = done_cnt + 1;
        end
    end

    logic [DW-1:0] words[$];
    bit            pat[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random(input int cnt);
        words.delete();
        for (int i = 0; i < cnt; i++) words.push_back(16'($urandom));
    endtask

    // Full load: expectations come from the word list, base and count.
    task automatic run_load(input int base, input int cnt, input bit use_pat, input bit exp_err);
        int k, guard, wr0, acc0, d0;
        logic [DW-1:0] sum;
        bit v;
        wr0 = wr_addr_q.size(); acc0 = acc_cyc_q.size(); d0 = done_cnt;
        sum = '0;
        foreach (words[i]) sum = sum + words[i];
        @(negedge clock);
        ifc.start = 1'b1; ifc.base_addr = AW'(base); ifc.word_count = (AW+1)'(cnt);
        @(negedge clock);
        ifc.start = 1'b0;
        chk("busy_load", ifc.busy, 1);
        chk("stall_load", ifc.core_stall, 1);
        chk("error_cleared", ifc.error, 0);
        k = 0; guard = 0;
        while (k < cnt && guard < 2000) begin
            chk("in_ready_load", ifc.in_ready, 1);
            if (use_pat) v = (guard < pat.size()) ? pat[guard] : 1'b1;
            else         v = ($urandom_range(0, 3) != 0);
            ifc.in_valid = v;
            ifc.in_data  = v ? words[k] : 16'($urandom);
            if (v && ifc.in_ready) k++;
            guard++;
            @(negedge clock);
        end
        chk("load_beats", k, cnt);
        ifc.in_valid = 1'b0;
        chk("flush_in_ready", ifc.in_ready, 0);
        chk("flush_busy", ifc.busy, 1);
        chk("flush_done", ifc.done, 0);
        @(negedge clock);
        for (int j = 0; j < cnt; j++) begin
            chk("verify_rd_addr", ifc.mem_rd_addr, (base + j) % DEPTH);
            chk("verify_done", ifc.done, 0);
            @(negedge clock);
        end
        chk("done_pulse", ifc.done, 1);
        chk("done_error", ifc.error, exp_err);
        chk("checksum", ifc.checksum, sum);
        @(negedge clock);
        chk("done_one_cycle", ifc.done, 0);
        chk("idle_busy", ifc.busy, 0);
        chk("idle_error_sticky", ifc.error, exp_err);
        chk("write_count", wr_addr_q.size() - wr0, cnt);
        for (int i = 0; i < cnt && (wr0 + i) < wr_addr_q.size(); i++) begin
            chk("write_addr", wr_addr_q[wr0 + i], (base + i) % DEPTH);
            chk("write_data", wr_data_q[wr0 + i], words[i]);
            if ((acc0 + i) < acc_cyc_q.size())
                chk("write_latency", wr_cyc_q[wr0 + i], acc_cyc_q[acc0 + i] + 1);
        end
        chk("done_pulses", done_cnt - d0, 1);
    endtask

    // count 0 or count > depth: straight to DONE, no writes.
    task automatic run_short(input int cnt, input bit exp_err);
        int wr0;
        wr0 = wr_addr_q.size();
        @(negedge clock);
        ifc.start = 1'b1; ifc.base_addr = AW'($urandom); ifc.word_count = (AW+1)'(cnt);
        @(negedge clock);
        ifc.start = 1'b0;
        chk("short_done", ifc.done, 1);
        chk("short_error", ifc.error, exp_err);
        chk("short_in_ready", ifc.in_ready, 0);
        @(negedge clock);
        chk("short_done_clear", ifc.done, 0);
        chk("short_busy", ifc.busy, 0);
        chk("short_no_writes", wr_addr_q.size() - wr0, 0);
    endtask

    initial begin
        int wr0, d0;
        reset = 1'b1;
        ifc.start = 1'b0; ifc.abort = 1'b0; ifc.base_addr = '0; ifc.word_count = '0;
        ifc.in_data = '0; ifc.in_valid = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_in_ready", ifc.in_ready, 0);
        chk("rst_wr_en", ifc.mem_wr_enable, 0);
        chk("rst_wr_addr", ifc.mem_wr_addr, 0);
        chk("rst_wr_data", ifc.mem_wr_data, 0);
        chk("rst_rd_addr", ifc.mem_rd_addr, 0);
        chk("rst_stall", ifc.core_stall, 0);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_done", ifc.done, 0);
        chk("rst_error", ifc.error, 0);
        chk("rst_checksum", ifc.checksum, 0);
        reset = 1'b0;

        // Directed back-to-back load from base 0.
        words = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        pat.delete();
        run_load(0, 4, 1'b1, 1'b0);
        chk("checksum_0a00", ifc.checksum, 16'h0A00);

        // Address wrap at the top of memory.
        fill_random(4);
        run_load(62, 4, 1'b1, 1'b0);

        // Stalled stream 1,0,0,1,1.
        fill_random(3);
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        run_load(20, 3, 1'b1, 1'b0);
        pat.delete();

        // Empty and illegal counts.
        run_short(0, 1'b0);
        run_short(DEPTH + 1, 1'b1);

        // Corrupted readback, then a clean load clears the error.
        corrupt = 1'b1; corrupt_addr = 6'd5;
        fill_random(6);
        run_load(3, 6, 1'b0, 1'b1);
        corrupt = 1'b0;
        fill_random(5);
        run_load(40, 5, 1'b0, 1'b0);

        // Full-depth load from a random base, then random loads.
        fill_random(DEPTH);
        run_load(int'($urandom_range(0, DEPTH - 1)), DEPTH, 1'b0, 1'b0);
        for (int n = 0; n < 4; n++) begin
            int c;
            c = int'($urandom_range(1, DEPTH));
            fill_random(c);
            run_load(int'($urandom_range(0, DEPTH - 1)), c, 1'b0, 1'b0);
        end

        // Abort after 2 of 5 beats, coinciding with a third valid beat.
        fill_random(5);
        wr0 = wr_addr_q.size(); d0 = done_cnt;
        @(negedge clock);
        ifc.start = 1'b1; ifc.base_addr = 6'd8; ifc.word_count = 7'd5;
        @(negedge clock);
        ifc.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ifc.in_valid = 1'b1; ifc.in_data = words[i];
            @(negedge clock);
        end
        ifc.abort = 1'b1; ifc.in_valid = 1'b1; ifc.in_data = words[2];
        @(negedge clock);
        ifc.abort = 1'b0; ifc.in_valid = 1'b0;
        chk("abort_busy", ifc.busy, 0);
        chk("abort_in_ready", ifc.in_ready, 0);
        chk("abort_error", ifc.error, 0);
        repeat (4) @(negedge clock);
        chk("abort_writes", wr_addr_q.size() - wr0, 2);
        chk("abort_no_done", done_cnt - d0, 0);

        // Reset asserted mid-VERIFY.
        fill_random(4);
        @(negedge clock);
        ifc.start = 1'b1; ifc.base_addr = 6'd10; ifc.word_count = 7'd4;
        @(negedge clock);
        ifc.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ifc.in_valid = 1'b1; ifc.in_data = words[i];
            @(negedge clock);
        end
        ifc.in_valid = 1'b0;
        repeat (3) @(negedge clock);   // FLUSH, VERIFY j=0, VERIFY j=1
        chk("pre_reset_rd_addr", ifc.mem_rd_addr, 12);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", ifc.busy, 0);
        chk("mid_rst_stall", ifc.core_stall, 0);
        chk("mid_rst_rd_addr", ifc.mem_rd_addr, 0);
        chk("mid_rst_wr_addr", ifc.mem_wr_addr, 0);
        chk("mid_rst_wr_data", ifc.mem_wr_data, 0);
        chk("mid_rst_checksum", ifc.checksum, 0);
        chk("mid_rst_done", ifc.done, 0);
        chk("mid_rst_in_ready", ifc.in_ready, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_idle", ifc.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
